sdrd_deserializer: RTL and testbench
====================================

SDRD_DESERIALIZER -- requirements
Module: sdrd_deserializer

Interface
REQ-001 SHALL have port clk, input, 1: single rising-edge system clock.
REQ-002 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have port SSER, input, 1: serial-device select, active low.
REQ-004 SHALL have ports BA13 and BA12, input, 1 each: bus address bits.
REQ-005 SHALL have port BA7_4, input, 4: bus address bits 7..4.
REQ-006 SHALL have port BR_W, input, 1: bus read/write, 1 = read.
REQ-007 SHALL have port SDRD, input, 1: serial data bit from the upstream serial-read stage, valid only during a window.
REQ-008 SHALL have port byte_ack, input, 1: consumer accepts byte_data, 1-cycle pulse.
REQ-009 SHALL have port byte_data, output, 8: assembled byte.
REQ-010 SHALL have port byte_valid, output, 1: byte_data holds an unconsumed byte.
REQ-011 SHALL have port overrun, output, 1: sticky lost-byte flag.
REQ-012 SHALL have port bit_cnt, output, 4: bits received in the current frame.
REQ-013 SHALL have port parity_err, output, 1: parity fault on the last byte, used only with SDRD_PARITY_EN.

Function
REQ-014 The window SHALL be ~SSER & ~BA13 & BA12 & BR_W, registered once (win_q).
REQ-015 The sample event SHALL be the first cycle of the window (win & ~win_q), giving one event per bus access, however long the access lasts.
REQ-016 A resync event SHALL be a sample event with BA7_4 = 4'hF; it SHALL clear bit_cnt and the shift register, SHALL NOT sample SDRD, and SHALL leave byte_valid, byte_data and overrun unchanged.
REQ-017 Every other sample event SHALL shift SDRD into the shift register MSB-first and increment bit_cnt.
REQ-018 Frame length N SHALL be 8 bits, or 9 bits with SDRD_PARITY_EN.
REQ-019 On the event that makes bit_cnt reach N, bit_cnt SHALL wrap to 0 in the same cycle; this is frame completion.
REQ-020 At completion with byte_valid = 0, byte_data SHALL load the 8 data bits, and byte_valid SHALL be 1 on the next cycle (1-cycle latency).
REQ-021 At completion with byte_valid = 1 and no byte_ack, byte_data SHALL be kept, overrun SHALL be set, and the new byte SHALL be discarded.
REQ-022 At completion coinciding with byte_ack, the new byte SHALL load, byte_valid SHALL stay 1, and overrun SHALL be unchanged.
REQ-023 byte_ack without completion SHALL clear byte_valid; byte_ack while byte_valid = 0 SHALL be ignored.
REQ-024 overrun SHALL clear only on reset, or on a resync event while byte_valid = 0.
REQ-025 Control SHALL be a 3-state FSM: IDLE (win = 0), ACCESS (win = 1, event processed), HOLD (win = 1 after the first cycle); HOLD/ACCESS return to IDLE when win drops.
REQ-026 Write cycles (BR_W = 0) and SSER = 1 SHALL never produce events.

Reset
REQ-027 With rst = 1 at a clk edge: byte_data = 8'h00, byte_valid = 0, overrun = 0, bit_cnt = 0, parity_err = 0, shift register = 0, win_q = 0, FSM = IDLE.
REQ-028 Reset SHALL override all simultaneous events, including in mid-frame and mid-access; an access still active when reset releases SHALL NOT produce an event until win has dropped and risen again.

Configuration
REQ-029 Macro SDRD_PARITY_EN, when defined: frames SHALL be 8 data bits + 1 odd-parity bit (9th bit last); parity_err SHALL be set at each accepted completion to 1 if the XOR of all 9 bits = 0, else 0.
REQ-030 Without SDRD_PARITY_EN: frames SHALL be 8 bits, parity_err SHALL be constant 0, and no parity logic SHALL be built.

Verification
REQ-031 Reset then 8 read accesses with SDRD = 1,0,1,0,0,1,0,1 -> byte_data = 8'hA5, byte_valid = 1 one cycle after the 8th event, bit_cnt = 0.
REQ-032 One read access held 5 cycles -> exactly one event, bit_cnt 0 -> 1.
REQ-033 Byte 8'h3C pending with no ack, then a second frame of 8'hFF -> byte_data stays 8'h3C and overrun = 1; a resync access after byte_ack -> overrun = 0.
REQ-034 byte_ack asserted on the same cycle as a completion carrying 8'h81 -> byte_valid stays 1, byte_data = 8'h81, overrun = 0.
REQ-035 3 data bits, then a resync access (BA7_4 = F), then 8 bits of 8'h5A -> byte_data = 8'h5A.
REQ-036 With SDRD_PARITY_EN: 8'h01 followed by parity bit 0 -> parity_err = 0; 8'h01 followed by parity bit 1 -> parity_err = 1.

Source files
------------

// File: rtl/sdrd_deserializer.sv
// rtl/sdrd_deserializer.sv - serial read-bit deserializer: one bit per bus read access, MSB-first, byte handoff
// Optional feature macro: SDRD_PARITY_EN (9-bit frames, 8 data bits followed by an odd-parity bit)
module sdrd_deserializer (
  input  logic       clk,
  input  logic       rst,
  input  logic       SSER,
  input  logic       BA13,
  input  logic       BA12,
  input  logic [3:0] BA7_4,
  input  logic       BR_W,
  input  logic       SDRD,
  input  logic       byte_ack,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       overrun,
  output logic [3:0] bit_cnt,
  output logic       parity_err
);

`ifdef SDRD_PARITY_EN
  localparam logic [3:0] FRAME_N = 4'd9;
`else
  localparam logic [3:0] FRAME_N = 4'd8;
`endif
  // Only the bits still needed at completion are stored; the final bit comes straight from SDRD.
  localparam int SW = int'(FRAME_N) - 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            win;
  logic            win_q, win_d;
  logic            arm_q, arm_d;
  logic            event_s;
  logic            resync;
  logic            sample;
  logic            complete;
  logic            accept;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      cnt_inc;
  logic [SW-1:0]   shift_q, shift_d;
  logic [7:0]      frame_byte;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ovr_q, ovr_d;

  always_comb begin
    win     = ~SSER & ~BA13 & BA12 & BR_W;
    win_d   = win;
    // arm_q blocks an access that was already in progress when reset released.
    arm_d   = arm_q | ~win;
    event_s = win & ~win_q & arm_q & (state_q == S_IDLE);
    resync  = event_s & (BA7_4 == 4'hF);
    sample  = event_s & ~resync;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (win) state_d = event_s ? S_ACCESS : S_HOLD;
      S_ACCESS: state_d = win ? S_HOLD : S_IDLE;
      S_HOLD:   if (!win) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_inc  = cnt_q + 4'd1;
    complete = sample & (cnt_inc == FRAME_N);
    accept   = complete & (~valid_q | byte_ack);
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    if (resync) begin
      cnt_d   = 4'd0;
      shift_d = '0;
    end else if (sample) begin
      shift_d = {shift_q[SW-2:0], SDRD};
      cnt_d   = complete ? 4'd0 : cnt_inc;
    end
`ifdef SDRD_PARITY_EN
    frame_byte = shift_q;
`else
    frame_byte = {shift_q, SDRD};
`endif
  end

  always_comb begin
    data_d  = accept ? frame_byte : data_q;
    valid_d = valid_q;
    if (complete) valid_d = 1'b1;
    else if (byte_ack) valid_d = 1'b0;
    ovr_d = ovr_q;
    if (complete & valid_q & ~byte_ack) ovr_d = 1'b1;
    else if (resync & ~valid_q) ovr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      win_q   <= 1'b0;
      arm_q   <= ~win;
      cnt_q   <= 4'd0;
      shift_q <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      arm_q   <= arm_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef SDRD_PARITY_EN
  logic perr_q, perr_d;

  // Odd parity: a good frame XORs to 1 across all nine bits.
  always_comb begin
    perr_d = accept ? ~(^{shift_q, SDRD}) : perr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= perr_d;
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign byte_data  = data_q;
  assign byte_valid = valid_q;
  assign overrun    = ovr_q;
  assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_sdrd_deserializer.sv
// tb/tb_sdrd_deserializer.sv - scoreboard bench for sdrd_deserializer (directed vectors)
module tb_sdrd_deserializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       SSER = 1'b1;
  logic       BA13 = 1'b0;
  logic       BA12 = 1'b0;
  logic [3:0] BA7_4 = 4'h0;
  logic       BR_W = 1'b0;
  logic       SDRD = 1'b0;
  logic       byte_ack = 1'b0;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       overrun;
  logic [3:0] bit_cnt;
  logic       parity_err;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  logic       prev_v = 1'b0;
  logic [7:0] prev_d = 8'h00;

  sdrd_deserializer dut (
    .clk(clk), .rst(rst), .SSER(SSER), .BA13(BA13), .BA12(BA12), .BA7_4(BA7_4),
    .BR_W(BR_W), .SDRD(SDRD), .byte_ack(byte_ack), .byte_data(byte_data),
    .byte_valid(byte_valid), .overrun(overrun), .bit_cnt(bit_cnt), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  // Monitor: every newly presented byte is popped from the scoreboard and compared.
  always @(negedge clk) begin
    logic [7:0] e;
    if (byte_valid && (!prev_v || byte_data != prev_d)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte: got %02h expected none", byte_data);
      end else begin
        e = exp_q.pop_front();
        if (byte_data !== e) begin
          errors++;
          $display("FAIL byte_data: got %02h expected %02h", byte_data, e);
        end
      end
    end
    prev_v <= byte_valid;
    prev_d <= byte_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_on(input logic sd, input logic [3:0] ba, input logic rw, input logic sser);
    SSER = sser; BA13 = 1'b0; BA12 = 1'b1; BR_W = rw; BA7_4 = ba; SDRD = sd;
  endtask

  task automatic bus_off();
    SSER = 1'b1; BR_W = 1'b0; BA12 = 1'b0; SDRD = 1'b0; BA7_4 = 4'h0;
  endtask

  task automatic access(input logic sd, input logic [3:0] ba, input int len,
                        input logic ack, input logic rw, input logic sser);
    bus_on(sd, ba, rw, sser);
    byte_ack = ack;
    step();
    byte_ack = 1'b0;
    repeat (len - 1) step();
    bus_off();
    step();
  endtask

  task automatic send_bit(input logic sd);
    access(sd, 4'h0, 1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic resync_access();
    access(1'b0, 4'hF, 1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic ack_byte();
    byte_ack = 1'b1;
    step();
    byte_ack = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic ack_last);
`ifdef SDRD_PARITY_EN
    for (int i = 0; i < 8; i++) send_bit(d[7-i]);
    access(~^d, 4'h0, 1, ack_last, 1'b1, 1'b0);
`else
    for (int i = 0; i < 7; i++) send_bit(d[7-i]);
    access(d[0], 4'h0, 1, ack_last, 1'b1, 1'b0);
`endif
  endtask

  initial begin
    logic [7:0] v;
    // Reset held with a read access already active.
    bus_on(1'b1, 4'h0, 1'b1, 1'b0);
    repeat (3) step();
    check("rst_byte_data", byte_data, 8'h00);
    check("rst_byte_valid", byte_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_bit_cnt", bit_cnt, 4'd0);
    check("rst_parity_err", parity_err, 1'b0);
    rst = 1'b0;
    repeat (3) step();
    check("no_event_after_reset", bit_cnt, 4'd0);
    bus_off();
    step();
    send_bit(1'b1);
    check("rearm_after_reset", bit_cnt, 4'd1);
    resync_access();
    check("resync_clears_cnt", bit_cnt, 4'd0);

    // Byte A5, valid only after the final event.
    v = 8'hA5;
    exp_q.push_back(v);
    for (int i = 0; i < 7; i++) send_bit(v[7-i]);
    check("a5_cnt_7", bit_cnt, 4'd7);
    check("a5_not_valid_early", byte_valid, 1'b0);
`ifdef SDRD_PARITY_EN
    send_bit(v[0]);
    check("a5_not_valid_8", byte_valid, 1'b0);
    send_bit(~^v);
`else
    send_bit(v[0]);
`endif
    check("a5_valid", byte_valid, 1'b1);
    check("a5_data", byte_data, 8'hA5);
    check("a5_cnt_wrap", bit_cnt, 4'd0);
    ack_byte();
    check("ack_clears_valid", byte_valid, 1'b0);

    // Long access yields exactly one event.
    access(1'b1, 4'h0, 5, 1'b0, 1'b1, 1'b0);
    check("hold5_one_event", bit_cnt, 4'd1);
    resync_access();

    // Overrun: 3C pending, FF discarded.
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b0);
    send_frame(8'hFF, 1'b0);
    check("ovr_data_kept", byte_data, 8'h3C);
    check("ovr_set", overrun, 1'b1);
    check("ovr_valid", byte_valid, 1'b1);
    resync_access();
    check("ovr_kept_while_valid", overrun, 1'b1);
    ack_byte();
    check("ovr_ack_valid", byte_valid, 1'b0);
    resync_access();
    check("ovr_cleared", overrun, 1'b0);

    // Completion coinciding with ack.
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    check("coinc_valid", byte_valid, 1'b1);
    check("coinc_data", byte_data, 8'h81);
    check("coinc_overrun", overrun, 1'b0);
    ack_byte();

    // Partial frame then resync.
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("partial_cnt", bit_cnt, 4'd3);
    resync_access();
    check("partial_resync", bit_cnt, 4'd0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0);
    check("resync_data", byte_data, 8'h5A);
    ack_byte();

    // Writes and deselected accesses never count.
    access(1'b1, 4'h0, 2, 1'b0, 1'b0, 1'b0);
    access(1'b1, 4'h0, 2, 1'b0, 1'b1, 1'b1);
    check("write_sser_no_event", bit_cnt, 4'd0);

`ifdef SDRD_PARITY_EN
    exp_q.push_back(8'h01);
    for (int i = 0; i < 8; i++) send_bit(i == 7);
    send_bit(1'b0);
    check("parity_ok", parity_err, 1'b0);
    ack_byte();
    step();
    exp_q.push_back(8'h01);
    for (int i = 0; i < 8; i++) send_bit(i == 7);
    send_bit(1'b1);
    check("parity_bad", parity_err, 1'b1);
    ack_byte();
`else
    check("parity_const0", parity_err, 1'b0);
`endif

    // Reset in mid-frame and mid-access.
    repeat (4) send_bit(1'b1);
    check("mid_cnt", bit_cnt, 4'd4);
    bus_on(1'b1, 4'h0, 1'b1, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (2) step();
    check("mid_reset_cnt", bit_cnt, 4'd0);
    check("mid_reset_valid", byte_valid, 1'b0);
    bus_off();
    repeat (3) step();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
